// File: rtl/uart_tx.sv
// UART transmitter with 5-8 data bits, optional parity, 1/2 stop bits and CTS gating, driven by a 16x baud tick.
// The start bit leaves 1 clk after acceptance (or after CTS falls); tx_start is dropped unless the block is idle.
module uart_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       cts_n,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CTS,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t     r_state;
  logic [7:0] r_data;
  logic [1:0] r_bits;
  logic       r_two_stop;
  logic       r_par_en;
  logic       r_par_type;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_idx;
  logic       r_stop_idx;
  logic       r_tx;
  logic       r_busy;
  logic       r_done;

  logic       w_bit_end;
  logic [2:0] w_last_idx;
  logic [2:0] w_next_idx;
  logic [7:0] w_mask;
  logic       w_parity;

  assign w_bit_end  = tick && (r_tick_cnt == 4'd15);
  // Width code 00..11 maps to a last data index of 4..7.
  assign w_last_idx = {1'b1, r_bits};
  assign w_next_idx = r_bit_idx + 3'd1;

  always_comb begin
    w_mask = 8'hFF;
    case (r_bits)
      2'b00:   w_mask = 8'h1F;
      2'b01:   w_mask = 8'h3F;
      2'b10:   w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
  end

  // Type 0 inverts the XOR for odd widths (5 and 7), which is what uart_rx checks against.
  assign w_parity = (^(r_data & w_mask)) ^ (~r_par_type & ~r_bits[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_data     <= 8'h00;
      r_bits     <= 2'b00;
      r_two_stop <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (tx_start) begin
            r_data     <= tx_data;
            r_bits     <= data_bit_num;
            r_two_stop <= stop_bit_num;
            r_par_en   <= parity_en;
            r_par_type <= parity_type;
            r_busy     <= 1'b1;
            if (!cts_n) begin
              r_state    <= S_START;
              r_tx       <= 1'b0;
              r_tick_cnt <= 4'd0;
            end else begin
              r_state <= S_WAIT_CTS;
            end
          end
        end

        S_WAIT_CTS: begin
          r_tx <= 1'b1;
          if (!cts_n) begin
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_tick_cnt <= 4'd0;
          end
        end

        S_START: begin
          if (tick) r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= 3'd0;
            r_tx      <= r_data[0];
          end
        end

        S_DATA: begin
          if (tick) r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_bit_end) begin
            if (r_bit_idx == w_last_idx) begin
              if (r_par_en) begin
                r_state <= S_PARITY;
                r_tx    <= w_parity;
              end else begin
                r_state    <= S_STOP;
                r_stop_idx <= 1'b0;
                r_tx       <= 1'b1;
              end
            end else begin
              r_bit_idx <= w_next_idx;
              r_tx      <= r_data[w_next_idx];
            end
          end
        end

        S_PARITY: begin
          if (tick) r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_bit_end) begin
            r_state    <= S_STOP;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
          end
        end

        S_STOP: begin
          r_tx <= 1'b1;
          if (tick) r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_bit_end) begin
            if (r_stop_idx == r_two_stop) begin
              // tx_busy stays high through the tx_done cycle and drops from IDLE.
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frames are sampled mid-bit by counting ticks from the start bit.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       cts_n;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int n_vec = 0;
  int n_err = 0;
  int tick_period = 2;
  int tick_phase = 0;

  uart_tx dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .cts_n        (cts_n),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_phase = tick_phase + 1;
      if (tick_phase >= tick_period) tick_phase = 0;
      tick = (tick_phase == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_cfg(input logic [1:0] nb, input logic sb, input logic pe, input logic pt);
    data_bit_num = nb;
    stop_bit_num = sb;
    parity_en    = pe;
    parity_type  = pt;
  endtask

  // Called at a negedge; the DUT samples the pulse on the following posedge only.
  task automatic pulse_start(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    fork
      begin
        @(negedge clk);
        tx_start = 1'b0;
      end
    join_none
  endtask

  // Returns at the negedge of the tx_done cycle; bit k is sampled at its 8th tick.
  task automatic get_frame(output logic [15:0] bits, output int ticks, output int wait_cyc,
                           output int busy_low, output bit done_seen);
    bits = '0;
    ticks = 0;
    wait_cyc = 0;
    busy_low = 0;
    done_seen = 1'b0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (tx !== 1'b0 && wait_cyc < 200);
    if (tx !== 1'b0) return;
    for (int c = 0; c < 2000; c++) begin
      if (tx_done === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      if (tx_busy !== 1'b1) busy_low++;
      if (tick === 1'b1) begin
        ticks++;
        if ((ticks % 16 == 8) && (ticks / 16 < 16)) bits[ticks/16] = tx;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tx_start = 1'b0;
    tx_data = 8'h00;
    cts_n = 1'b0;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_vec++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", tx_done); end
    rst = 1'b0;
    pulse_start(8'hA5);
    @(negedge clk);
    n_vec++; if (tx_busy !== 1'b1) begin n_err++; $display("FAIL first_clk_accept_busy: got %b want 1", tx_busy); end
    n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL first_clk_accept_tx: got %b want 0", tx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_abort_busy: got %b want 0", tx_busy); end
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_abort_tx: got %b want 1", tx); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1;
    logic [15:0] bits; int ticks, wc, bl; bit ds;
    tick_period = 2;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    pulse_start(8'hA5);
    get_frame(bits, ticks, wc, bl, ds);
    n_vec++; if (ds !== 1'b1) begin n_err++; $display("FAIL 8n1_done: got %b want 1", ds); end
    n_vec++; if (ticks != 160) begin n_err++; $display("FAIL 8n1_ticks: got %0d want 160", ticks); end
    n_vec++; if (bits !== 16'h034A) begin n_err++; $display("FAIL 8n1_bits: got %h want 034a", bits); end
    n_vec++; if (wc != 1) begin n_err++; $display("FAIL 8n1_start_latency: got %0d want 1", wc); end
    n_vec++; if (bl != 0) begin n_err++; $display("FAIL 8n1_busy_gap: got %0d low cycles want 0", bl); end
    n_vec++; if (tx_busy !== 1'b1) begin n_err++; $display("FAIL 8n1_busy_at_done: got %b want 1", tx_busy); end
    @(negedge clk);
    n_vec++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL 8n1_done_width: got %b want 0", tx_done); end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL 8n1_busy_drop: got %b want 0", tx_busy); end
  endtask

  task automatic test_5bit_parity;
    logic [15:0] bits; int ticks, wc, bl; bit ds;
    tick_period = 2;
    set_cfg(2'b00, 1'b0, 1'b1, 1'b1);
    pulse_start(8'hFF);
    // CTS dropping mid-frame must not stall the frame.
    fork
      begin
        @(negedge clk);
        cts_n = 1'b1;
      end
    join_none
    get_frame(bits, ticks, wc, bl, ds);
    cts_n = 1'b0;
    n_vec++; if (ds !== 1'b1) begin n_err++; $display("FAIL 5e_done: got %b want 1", ds); end
    n_vec++; if (ticks != 128) begin n_err++; $display("FAIL 5e_ticks: got %0d want 128", ticks); end
    n_vec++; if (bits !== 16'h00FE) begin n_err++; $display("FAIL 5e_bits: got %h want 00fe", bits); end
    @(negedge clk);
  endtask

  task automatic test_7bit_two_stop;
    logic [15:0] bits; int ticks, wc, bl; bit ds;
    tick_period = 2;
    set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
    pulse_start(8'h00);
    get_frame(bits, ticks, wc, bl, ds);
    n_vec++; if (ds !== 1'b1) begin n_err++; $display("FAIL 7o2_done: got %b want 1", ds); end
    n_vec++; if (ticks != 176) begin n_err++; $display("FAIL 7o2_ticks: got %0d want 176", ticks); end
    n_vec++; if (bits !== 16'h0700) begin n_err++; $display("FAIL 7o2_bits: got %h want 0700", bits); end
    @(negedge clk);
  endtask

  task automatic test_6bit_slow_tick;
    logic [15:0] bits; int ticks, wc, bl; bit ds;
    tick_period = 3;
    set_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    pulse_start(8'hED);
    // Inputs change after the latch; the frame must use the latched values.
    fork
      begin
        @(negedge clk);
        @(negedge clk);
        tx_data = 8'h00;
        set_cfg(2'b11, 1'b1, 1'b0, 1'b1);
      end
    join_none
    get_frame(bits, ticks, wc, bl, ds);
    n_vec++; if (ds !== 1'b1) begin n_err++; $display("FAIL 6e_done: got %b want 1", ds); end
    n_vec++; if (ticks != 144) begin n_err++; $display("FAIL 6e_ticks: got %0d want 144", ticks); end
    n_vec++; if (bits !== 16'h015A) begin n_err++; $display("FAIL 6e_bits: got %h want 015a", bits); end
    n_vec++; if (bl != 0) begin n_err++; $display("FAIL 6e_busy_gap: got %0d low cycles want 0", bl); end
    tick_period = 2;
    @(negedge clk);
  endtask

  task automatic test_cts_wait;
    logic [15:0] bits; int ticks, wc, bl; bit ds;
    int bad_tx, bad_busy, extra;
    bad_tx = 0; bad_busy = 0; extra = 0;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    cts_n = 1'b1;
    pulse_start(8'h5A);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (tx_busy !== 1'b1) bad_busy++;
      if (i == 20) begin tx_data = 8'h00; tx_start = 1'b1; end
      if (i == 21) tx_start = 1'b0;
    end
    n_vec++; if (bad_tx != 0) begin n_err++; $display("FAIL cts_hold_tx: got %0d low cycles want 0", bad_tx); end
    n_vec++; if (bad_busy != 0) begin n_err++; $display("FAIL cts_hold_busy: got %0d idle cycles want 0", bad_busy); end
    cts_n = 1'b0;
    get_frame(bits, ticks, wc, bl, ds);
    n_vec++; if (wc != 1) begin n_err++; $display("FAIL cts_start_latency: got %0d want 1", wc); end
    n_vec++; if (ds !== 1'b1) begin n_err++; $display("FAIL cts_done: got %b want 1", ds); end
    n_vec++; if (ticks != 160) begin n_err++; $display("FAIL cts_ticks: got %0d want 160", ticks); end
    n_vec++; if (bits !== 16'h02B4) begin n_err++; $display("FAIL cts_bits: got %h want 02b4", bits); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) extra++;
    end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL cts_no_queue: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] bits; int ticks, wc, bl; bit ds;
    int cnt, dones;
    cnt = 0; dones = 0;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    pulse_start(8'hA5);
    for (int c = 0; c < 500 && cnt < 40; c++) begin
      @(negedge clk);
      if (tick === 1'b1) cnt++;
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL midrst_tx: got %b want 1", tx); end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", tx_busy); end
    n_vec++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", tx_done); end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_done !== 1'b0) dones++;
    end
    n_vec++; if (dones != 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", dones); end
    pulse_start(8'h3C);
    get_frame(bits, ticks, wc, bl, ds);
    n_vec++; if (ds !== 1'b1) begin n_err++; $display("FAIL midrst_next_done: got %b want 1", ds); end
    n_vec++; if (bits !== 16'h0278) begin n_err++; $display("FAIL midrst_next_bits: got %h want 0278", bits); end
    n_vec++; if (ticks != 160) begin n_err++; $display("FAIL midrst_next_ticks: got %0d want 160", ticks); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [15:0] bits; int ticks, wc, bl; bit ds;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    pulse_start(8'h81);
    get_frame(bits, ticks, wc, bl, ds);
    n_vec++; if (ds !== 1'b1) begin n_err++; $display("FAIL b2b_first_done: got %b want 1", ds); end
    n_vec++; if (bits !== 16'h0302) begin n_err++; $display("FAIL b2b_first_bits: got %h want 0302", bits); end
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL b2b_gap_tx: got %b want 1", tx); end
    pulse_start(8'h7E);
    get_frame(bits, ticks, wc, bl, ds);
    n_vec++; if (wc != 1) begin n_err++; $display("FAIL b2b_gap_len: got %0d want 1", wc); end
    n_vec++; if (ds !== 1'b1) begin n_err++; $display("FAIL b2b_second_done: got %b want 1", ds); end
    n_vec++; if (bits !== 16'h02FC) begin n_err++; $display("FAIL b2b_second_bits: got %h want 02fc", bits); end
    n_vec++; if (bl != 0) begin n_err++; $display("FAIL b2b_busy_gap: got %0d low cycles want 0", bl); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_5bit_parity();
    test_7bit_two_stop();
    test_6bit_slow_tick();
    test_cts_wait();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide exactly one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports: clk, input, 1, sole clock, all logic on rising edge.
REQ-003 SHALL have ports: rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports: tick, input, 1, 16x baud enable, one clk wide.
REQ-005 SHALL have ports: tx_start, input, 1, request to send tx_data, one clk pulse.
REQ-006 SHALL have ports: tx_data, input, 8, frame payload, LSB first.
REQ-007 SHALL have ports: data_bit_num, input, 2, data width: 00=5, 01=6, 10=7, 11=8.
REQ-008 SHALL have ports: stop_bit_num, input, 1, 0=one stop bit, 1=two.
REQ-009 SHALL have ports: parity_en, input, 1, insert parity bit.
REQ-010 SHALL have ports: parity_type, input, 1, parity rule select (REQ-020).
REQ-011 SHALL have ports: cts_n, input, 1, active-low clear-to-send from peer.
REQ-012 SHALL have ports: tx, output, 1, serial line, idle high.
REQ-013 SHALL have ports: tx_busy, output, 1, request pending or frame in progress.
REQ-014 SHALL have ports: tx_done, output, 1, one-clk pulse at frame end.

Function
REQ-015 SHALL implement states IDLE, WAIT_CTS, START, DATA, PARITY, STOP.
REQ-016 IDLE: tx_start SHALL latch tx_data, data_bit_num, stop_bit_num, parity_en, parity_type.
- Next state is START if cts_n=0 that cycle, else WAIT_CTS.
- Input changes after the latch do not affect the frame.
REQ-017 WAIT_CTS SHALL advance to START on the first clk with cts_n=0.
- No timeout.
- tx_start is ignored while waiting.
REQ-018 Bit timing:
- Every bit lasts exactly 16 ticks, counted by a 4-bit tick counter.
- A bit ends on a clk where tick=1 and the counter is 15.
- The counter clears on entry to START.
REQ-019 tx drive and transitions:
- START: tx=0.
- DATA: tx=shift[bit_idx], bit_idx 0..n-1; after bit n-1, go to PARITY if parity_en, else STOP.
- PARITY: tx=parity bit.
- STOP: tx=1 for 1 or 2 bits, then IDLE.
- IDLE/WAIT_CTS: tx=1.
REQ-020 Parity bit (n = data width), matching uart_rx's check:
- parity_type=1: XOR of the n data bits.
- parity_type=0: XOR of the n data bits, inverted when n is odd (5 or 7).
REQ-021 tx SHALL be registered; tx changes only on clk edges.
REQ-022 tx_busy SHALL be high from the clk after tx_start acceptance until the cycle tx_done pulses, inclusive.
- tx_busy drops the clk after tx_done.
REQ-023 tx_done SHALL pulse high for exactly one clk, in the cycle after the final tick of the last stop bit, concurrent with return to IDLE.
REQ-024 tx_start while not in IDLE SHALL be ignored; no queueing.
REQ-025 Back-to-back frames: tx_start in the first IDLE cycle (tx_done low) SHALL be accepted.
- Minimum line-idle gap is 1 clk.
REQ-026 Mid-frame cts_n deassertion SHALL NOT stall or abort the current frame.
REQ-027 Frame length SHALL be (1 + n + parity_en + 1 + stop_bit_num) x 16 ticks.
REQ-028 Data bits above n-1 SHALL never be transmitted.
REQ-029 tick=0 SHALL freeze all counters and state, except the IDLE and WAIT_CTS transitions, which are clk-driven.

Reset
REQ-030 rst=1 SHALL force, on the next clk edge:
- state=IDLE; counters=0.
- tx=1, tx_busy=0, tx_done=0.
REQ-031 Reset SHALL take priority over all inputs, including mid-frame, abandoning the frame without a tx_done pulse.
REQ-032 After rst deasserts, the block SHALL accept tx_start on the first clk.

Verification
REQ-033 8N1, parity off, cts_n=0, tx_data=0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each 16 ticks; tx_done pulses after tick 160.
REQ-034 5-bit, parity_en=1, parity_type=1, tx_data=0xFF -> bit sequence 0,1,1,1,1,1,1(parity),1(stop); 128 ticks total; bits 5-7 never sent.
REQ-035 7-bit, parity_type=0, two stop bits, tx_data=0x00 -> parity bit 1; 11 bits = 176 ticks; looped-back uart_rx reports parity_error=0 and rx_data=0x00.
REQ-036 cts_n=1 at tx_start, held 50 clks, then 0 -> tx stays 1 and tx_busy=1 while held; start bit begins the clk after cts_n falls; a second tx_start while waiting is ignored.
REQ-037 rst pulse at tick 40 of an 8N1 frame -> next clk tx=1, tx_busy=0, no tx_done; a following tx_start of 0x3C transmits correctly.
REQ-038 tx_start asserted in the first IDLE cycle after tx_done -> second frame starts with 1 idle clk gap; both payloads received intact.
